// File: rtl/mult_pkg.sv
// Shared types for the radix-2 Booth sequential multiplier: FSM states,
// Booth recoding operations and the recoding helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Radix-2 recoding of the {Q0, Q_1} bit pair.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    booth_op_e op;
    case ({q0, q_1})
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A,
// then arithmetic right shift of the {A, Q, Q_1} chain.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] q_i,
  input  logic           q_1_i,
  input  logic [WIDTH:0] m_i,
  output logic [WIDTH:0] a_o,
  output logic [WIDTH:0] q_o,
  output logic           q_1_o
);

  booth_op_e      op;
  logic [WIDTH:0] a_sum;

  always_comb begin
    op    = booth_decode(q_i[0], q_1_i);
    a_sum = a_i;
    case (op)
      OP_ADD:  a_sum = a_i + m_i;
      OP_SUB:  a_sum = a_i - m_i;
      default: a_sum = a_i;
    endcase
    // Sign bit of A is replicated; the bit shifted out of A enters the top of Q.
    a_o   = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_o   = {a_sum[0], q_i[WIDTH:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per transaction,
// with valid/ready handshakes on the operand and product sides.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high; the producer holds valid and its data stable
// until that edge, and ready never depends combinationally on valid.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               dest_valid,
  input  logic               dest_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output mult_state_e        state_dbg
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH + 1);

  mult_state_e        state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     a_q, q_q, m_q;
  logic               q_1_q;
  logic [WIDTH:0]     a_d, q_d;
  logic               q_1_d;
  logic               src_ready_q, dest_valid_q, busy_q;
  logic [2*WIDTH-1:0] product_q;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .q_1_i (q_1_q),
    .m_i   (m_q),
    .a_o   (a_d),
    .q_o   (q_d),
    .q_1_o (q_1_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      q_q          <= '0;
      q_1_q        <= 1'b0;
      m_q          <= '0;
      src_ready_q  <= 1'b1;
      dest_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      product_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (src_valid) begin
            // One extra bit keeps unsigned operands positive and -M representable.
            m_q         <= is_signed ? {multiplicand[WIDTH-1], multiplicand}
                                     : {1'b0, multiplicand};
            q_q         <= is_signed ? {multiplier[WIDTH-1], multiplier}
                                     : {1'b0, multiplier};
            a_q         <= '0;
            q_1_q       <= 1'b0;
            cnt_q       <= '0;
            src_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == LAST_CNT) begin
            product_q    <= {a_q[WIDTH-2:0], q_q};
            dest_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            q_1_q <= q_1_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (dest_ready) begin
            dest_valid_q <= 1'b0;
            src_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          src_ready_q  <= 1'b1;
          dest_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign src_ready  = src_ready_q;
  assign dest_valid = dest_valid_q;
  assign busy       = busy_q;
  assign product    = product_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier (WIDTH=8): vector table plus
// backpressure, mid-CALC input pulse and mid-CALC reset sequences.
module tb_booth_seq_multiplier;
  import mult_pkg::*;

  localparam int W = 8;
  localparam int LAT = W + 2;

  logic           clk;
  logic           rst;
  logic           src_valid;
  logic           src_ready;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           dest_valid;
  logic           dest_ready;
  logic [2*W-1:0] product;
  logic           busy;
  mult_state_e    state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .dest_valid   (dest_valid),
    .dest_ready   (dest_ready),
    .product      (product),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one operand set and returns #1 after the accept edge.
  task automatic accept(input logic sgn, input logic [W-1:0] m, input logic [W-1:0] q);
    is_signed    = sgn;
    multiplicand = m;
    multiplier   = q;
    src_valid    = 1'b1;
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask

  // Waits (bounded) for dest_valid, counting edges since accept; optionally
  // pulses src_valid with junk operands at edge pulse_at.
  task automatic wait_result(input string name, input logic [2*W-1:0] exp, input int pulse_at);
    int n;
    n = 0;
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_src_ready_low"}, {31'd0, src_ready}, 32'd0);
    while (!dest_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == pulse_at) begin
        is_signed    = 1'b0;
        multiplicand = 8'h5A;
        multiplier   = 8'hC3;
        src_valid    = 1'b1;
      end else if (n == pulse_at + 1) begin
        src_valid = 1'b0;
      end
    end
    src_valid = 1'b0;
    check({name, "_latency"}, n, LAT);
    check({name, "_product"}, {16'd0, product}, {16'd0, exp});
  endtask

  task automatic release_out(input string name);
    dest_ready = 1'b1;
    @(posedge clk);
    #1;
    dest_ready = 1'b0;
    check({name, "_valid_drop"}, {31'd0, dest_valid}, 32'd0);
    check({name, "_src_ready_back"}, {31'd0, src_ready}, 32'd1);
  endtask

  initial begin
    rst          = 1'b0;
    src_valid    = 1'b0;
    dest_ready   = 1'b0;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // sgn, M, Q, expected product (hand-computed)
    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};  // -128 * -128
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};  // 255 * 255
    vecs[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};  // -1 * 1
    vecs[3]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};  // 255 * 1
    vecs[4]  = '{1'b0, 8'h00, 8'hAB, 16'h0000};  // 0 * 171
    vecs[5]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};  // 127 * -128
    vecs[6]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};  // -128 * 127
    vecs[7]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C};  // 12 * 13
    vecs[8]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};  // -3 * 5
    vecs[9]  = '{1'b1, 8'h00, 8'h80, 16'h0000};  // 0 * -128
    vecs[10] = '{1'b0, 8'h80, 8'h80, 16'h4000};  // 128 * 128
    vecs[11] = '{1'b0, 8'h7F, 8'h80, 16'h3F80};  // 127 * 128
    vecs[12] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};  // 127 * 127

    repeat (2) @(posedge clk);
    #1;
    check("rst_src_ready", {31'd0, src_ready}, 32'd1);
    check("rst_dest_valid", {31'd0, dest_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      accept(vecs[i].sgn, vecs[i].m, vecs[i].q);
      wait_result($sformatf("vec%0d", i), vecs[i].exp, -1);
      release_out($sformatf("vec%0d", i));
    end

    // Backpressure in DONE with src_valid also asserted.
    accept(1'b0, 8'h10, 8'h10);
    wait_result("bp", 16'h0100, -1);
    for (int i = 0; i < 5; i++) begin
      is_signed    = 1'b1;
      multiplicand = 8'h55;
      multiplier   = 8'h55;
      src_valid    = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, dest_valid}, 32'd1);
      check("bp_hold_product", {16'd0, product}, 32'h0100);
      check("bp_hold_src_ready", {31'd0, src_ready}, 32'd0);
    end
    is_signed    = 1'b0;
    multiplicand = 8'h03;
    multiplier   = 8'h04;
    dest_ready   = 1'b1;
    @(posedge clk);
    #1;
    dest_ready = 1'b0;
    check("bp_idle_src_ready", {31'd0, src_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, dest_valid}, 32'd0);
    check("bp_idle_product_kept", {16'd0, product}, 32'h0100);
    accept(1'b0, 8'h03, 8'h04);
    wait_result("bp_second", 16'h000C, -1);
    release_out("bp_second");

    // src_valid pulse while CALC must not disturb the running operation.
    accept(1'b1, 8'h85, 8'h33);
    wait_result("midpulse", 16'hE77F, 3);
    release_out("midpulse");

    // Asynchronous reset during CALC, then a fresh operation.
    accept(1'b0, 8'hFF, 8'hFF);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mrst_src_ready", {31'd0, src_ready}, 32'd1);
    check("mrst_dest_valid", {31'd0, dest_valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_product", {16'd0, product}, 32'd0);
    check("mrst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    accept(1'b1, 8'hF6, 8'h0B);  // -10 * 11 = -110
    wait_result("post_rst", 16'hFF92, -1);
    release_out("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
